cache_fsm_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller between the CPU request port and the main-memory port. It accepts one `cpu_req_type` transaction at a time and returns a `cpu_result_type`. On a miss it issues `mem_req_type` transactions (dirty write-back, then line fill) and consumes `mem_data_type` responses. Geometry: 1024 lines × 256 bits, 32-bit words.

---
 rtl/cache_def.sv | 47 ++++
 rtl/cache_line_store.sv | 26 ++
 rtl/cache_fsm_ctrl.sv | 142 ++++++++++++++
 tb/tb_cache_fsm_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_def.sv
// Shared types and geometry for the direct-mapped write-back cache controller.
// Optional statistics counters are enabled with CACHE_STATS_EN.
package cache_def;

  localparam int TAGMSB = 31;
  localparam int TAGLSB = 15;
  localparam int NumLines = 1024;

  typedef struct packed {
    logic                dirty;
    logic [TAGMSB:TAGLSB] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [9:0] index;
    logic       we;
  } cache_req_type;

  typedef logic [255:0] cache_data_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]  addr;
    logic [255:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [255:0] data;
    logic         ready;
  } mem_data_type;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} cache_state_type;

endpackage

// File: rtl/cache_line_store.sv
// Tag (dirty + tag) and data arrays: combinational read, registered write.
module cache_line_store
  import cache_def::*;
(
  input  logic           clk,
  input  cache_req_type  data_req,
  input  cache_tag_type  tag_write,
  input  cache_data_type data_write,
  output cache_tag_type  tag_read,
  output cache_data_type data_read
);

  cache_tag_type  tag_mem  [NumLines];
  cache_data_type data_mem [NumLines];

  assign tag_read  = tag_mem[data_req.index];
  assign data_read = data_mem[data_req.index];

  always_ff @(posedge clk) begin
    if (data_req.we) begin
      tag_mem[data_req.index]  <= tag_write;
      data_mem[data_req.index] <= data_write;
    end
  end

endmodule

// File: rtl/cache_fsm_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller FSM.
// Hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_fsm_ctrl
  import cache_def::*;
(
  input  logic           clk,
  input  logic           rst,
  input  cpu_req_type    cpu_req,
  input  mem_data_type   mem_data,
  output cpu_result_type cpu_res,
  output mem_req_type    mem_req,
  output logic [31:0]    hit_count,
  output logic [31:0]    miss_count
);

  cache_state_type state_q, state_d;
  cpu_req_type     req_q;
  logic [NumLines-1:0] valid_q;
  logic            set_valid;

  cache_req_type  store_req;
  cache_tag_type  tag_read, tag_write;
  cache_data_type data_read, data_write;

  logic [9:0]           index;
  logic [TAGMSB:TAGLSB] req_tag;
  logic [2:0]           word;
  logic                 hit;

  assign index   = req_q.addr[14:5];
  assign req_tag = req_q.addr[TAGMSB:TAGLSB];
  assign word    = req_q.addr[4:2];
  assign hit     = valid_q[index] && (tag_read.tag == req_tag);

  logic unused_req;
  assign unused_req = ^{req_q.addr[1:0], req_q.valid};

  cache_line_store u_store (
    .clk        (clk),
    .data_req   (store_req),
    .tag_write  (tag_write),
    .data_write (data_write),
    .tag_read   (tag_read),
    .data_read  (data_read)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      // Request is captured once; later CPU-side changes do not affect it.
      if (state_q == IDLE && cpu_req.valid) req_q <= cpu_req;
      if (set_valid) valid_q[index] <= 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    cpu_res         = '0;
    mem_req         = '0;
    store_req.index = index;
    store_req.we    = 1'b0;
    tag_write       = tag_read;
    data_write      = data_read;
    set_valid       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req.valid) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_res.ready = 1'b1;
          if (req_q.rw) begin
            store_req.we                   = 1'b1;
            tag_write.dirty                = 1'b1;
            data_write[{word, 5'b0} +: 32] = req_q.data;
          end else begin
            cpu_res.data = data_read[{word, 5'b0} +: 32];
          end
          state_d = IDLE;
        end else if (valid_q[index] && tag_read.dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req.valid = 1'b1;
        mem_req.rw    = 1'b1;
        mem_req.addr  = {tag_read.tag, index, 5'b0};
        mem_req.data  = data_read;
        if (mem_data.ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req.valid = 1'b1;
        mem_req.rw    = 1'b0;
        mem_req.addr  = {req_tag, index, 5'b0};
        if (mem_data.ready) begin
          store_req.we    = 1'b1;
          tag_write.tag   = req_tag;
          tag_write.dirty = 1'b0;
          data_write      = mem_data.data;
          set_valid       = 1'b1;
          state_d         = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic        refill_q;
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refill_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      // The compare following a fill is not a new lookup and is not counted.
      if (state_q == ALLOCATE && mem_data.ready) refill_q <= 1'b1;
      else if (state_q == COMPARE)               refill_q <= 1'b0;
      if (state_q == COMPARE && !refill_q) begin
        if (hit && hit_q != 32'hFFFF_FFFF)        hit_q  <= hit_q + 32'd1;
        else if (!hit && miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_fsm_ctrl.sv
// Self-checking bench for cache_fsm_ctrl: behavioural cache/memory model plus directed vectors.
module tb_cache_fsm_ctrl;
  import cache_def::*;

  logic           clk = 1'b0;
  logic           rst;
  cpu_req_type    cpu_req;
  mem_data_type   mem_data;
  cpu_result_type cpu_res;
  mem_req_type    mem_req;
  logic [31:0]    hit_count, miss_count;

  always #5 clk = ~clk;

  cache_fsm_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .mem_data   (mem_data),
    .cpu_res    (cpu_res),
    .mem_req    (mem_req),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: per-line state plus a sparse main memory.
  bit           m_valid [1024];
  bit           m_dirty [1024];
  logic [16:0]  m_tag   [1024];
  logic [255:0] m_line  [1024];
  logic [255:0] mainmem [logic [31:0]];
  int           exp_hits, exp_misses;

  typedef struct {
    logic [31:0]  addr;
    logic         rw;
    logic [255:0] data;
  } mtx_t;
  mtx_t exp_q[$];

  logic [31:0]  last_wb_addr, last_alloc_addr;
  logic [255:0] last_wb_data;

  function automatic logic [255:0] mem_get(input logic [31:0] a);
    logic [255:0] r;
    if (mainmem.exists(a)) return mainmem[a];
    for (int w = 0; w < 8; w++) r[32*w +: 32] = a ^ {4{8'(w)}} ^ 32'hA5A5_0000;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
`ifdef CACHE_STATS_EN
    check({tag, " hit_count"}, 512'(hit_count), 512'(exp_hits));
    check({tag, " miss_count"}, 512'(miss_count), 512'(exp_misses));
`else
    check({tag, " hit_count"}, 512'(hit_count), 512'(0));
    check({tag, " miss_count"}, 512'(miss_count), 512'(0));
`endif
  endtask

  task automatic cpu_op(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                        input int delay, output logic [31:0] rdata, output int lat);
    int          idx, w, cnt;
    logic [16:0] tag;
    logic        hit, pending, done;
    logic [31:0] exp_rd;
    mtx_t        t;
    mem_req_type cap;

    idx = int'(addr[14:5]);
    w   = int'(addr[4:2]);
    tag = addr[31:15];
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (hit) begin
      exp_hits++;
    end else begin
      exp_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        t.addr = {m_tag[idx], addr[14:5], 5'b0};
        t.rw   = 1'b1;
        t.data = m_line[idx];
        exp_q.push_back(t);
        mainmem[t.addr] = m_line[idx];
      end
      t.addr = {tag, addr[14:5], 5'b0};
      t.rw   = 1'b0;
      t.data = '0;
      exp_q.push_back(t);
      m_line[idx]  = mem_get(t.addr);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    exp_rd = m_line[idx][32*w +: 32];
    if (rw) begin
      m_line[idx][32*w +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end

    @(posedge clk);
    @(negedge clk);
    cpu_req.addr  = addr;
    cpu_req.rw    = rw;
    cpu_req.data  = wdata;
    cpu_req.valid = 1'b1;
    rdata   = '0;
    lat     = 0;
    cnt     = 0;
    pending = 1'b0;
    done    = 1'b0;
    cap     = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      #1;
      lat++;
      mem_data.ready = 1'b0;
      if (cpu_res.ready) begin
        done          = 1'b1;
        rdata         = cpu_res.data;
        cpu_req.valid = 1'b0;
      end else if (mem_req.valid) begin
        if (!pending) begin
          pending = 1'b1;
          cap     = mem_req;
          cnt     = 0;
          if (exp_q.size() == 0) begin
            check("unexpected mem_req", 512'(1), 512'(0));
          end else begin
            t = exp_q.pop_front();
            check("mem_req addr", 512'(cap.addr), 512'(t.addr));
            check("mem_req rw", 512'(cap.rw), 512'(t.rw));
            if (t.rw) begin
              check("writeback data", 512'(cap.data), 512'(t.data));
              last_wb_addr = cap.addr;
              last_wb_data = cap.data;
            end else begin
              last_alloc_addr = cap.addr;
            end
          end
        end else begin
          check("mem_req stable", 512'(mem_req), 512'(cap));
        end
        if (cnt >= delay) begin
          mem_data.ready = 1'b1;
          mem_data.data  = cap.rw ? '0 : mem_get(cap.addr);
          pending        = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
    mem_data.ready = 1'b0;
    if (!done) check("cpu_res.ready timeout", 512'(0), 512'(1));
    check("mem transactions left", 512'(exp_q.size()), 512'(0));
    exp_q.delete();
    if (!rw) check("read data", 512'(rdata), 512'(exp_rd));
    if (hit) check("hit latency", 512'(lat), 512'(1));
    check_counters("op");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0]  rd;
    logic [255:0] tmp;
    int           lat;
    logic         seen;

    rst      = 1'b1;
    cpu_req  = '0;
    mem_data = '0;
    model_reset();
    last_wb_addr    = '0;
    last_wb_data    = '0;
    last_alloc_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset cpu_res", 512'(cpu_res), 512'(0));
    check("reset mem_req", 512'(mem_req), 512'(0));
    check("reset hit_count", 512'(hit_count), 512'(0));
    check("reset miss_count", 512'(miss_count), 512'(0));
    @(negedge clk);
    rst = 1'b0;

    tmp = mem_get(32'h0000_1000);
    tmp[31:0] = 32'h1111_1111;
    mainmem[32'h0000_1000] = tmp;

    // Clean miss fill then read.
    cpu_op(32'h0000_1000, 1'b0, 32'h0, 2, rd, lat);
    check("t1 read word0", 512'(rd), 512'(32'h1111_1111));
    check("t1 alloc addr", 512'(last_alloc_addr), 512'(32'h0000_1000));
`ifdef CACHE_STATS_EN
    check("t1 miss_count literal", 512'(miss_count), 512'(1));
`endif

    cpu_op(32'h0000_1004, 1'b0, 32'h0, 0, rd, lat);
    check("t2 hit latency literal", 512'(lat), 512'(1));
`ifdef CACHE_STATS_EN
    check("t2 hit_count literal", 512'(hit_count), 512'(1));
`endif

    cpu_op(32'h0000_1008, 1'b1, 32'hDEAD_BEEF, 0, rd, lat);
    check("t3 write latency", 512'(lat), 512'(1));
    cpu_op(32'h0000_1008, 1'b0, 32'h0, 0, rd, lat);
    check("t3 read back literal", 512'(rd), 512'(32'hDEAD_BEEF));

    // Conflict on index 0x080 with a dirty line: write-back then fill.
    last_alloc_addr = '0;
    cpu_op(32'h0000_9008, 1'b0, 32'h0, 1, rd, lat);
    check("t4 wb addr literal", 512'(last_wb_addr), 512'(32'h0000_1000));
    check("t4 wb word2 literal", 512'(last_wb_data[95:64]), 512'(32'hDEAD_BEEF));
    check("t4 alloc addr literal", 512'(last_alloc_addr), 512'(32'h0000_9000));

    // Slow memory: fields must hold for the whole wait.
    cpu_op(32'h0001_1010, 1'b0, 32'h0, 10, rd, lat);
    cpu_op(32'h0000_2014, 1'b1, 32'h1234_5678, 3, rd, lat);
    cpu_op(32'h0000_2014, 1'b0, 32'h0, 0, rd, lat);
    check("t5 write-allocate read literal", 512'(rd), 512'(32'h1234_5678));
    cpu_op(32'h0001_1010, 1'b1, 32'hCAFE_0001, 0, rd, lat);
    cpu_op(32'h0000_1000, 1'b0, 32'h0, 4, rd, lat);
    check("t5 refetch of written-back line", 512'(rd), 512'(32'h1111_1111));

    // Reset while a fill is outstanding.
    @(posedge clk);
    @(negedge clk);
    cpu_req.addr  = 32'h0000_3000;
    cpu_req.rw    = 1'b0;
    cpu_req.data  = '0;
    cpu_req.valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (mem_req.valid) seen = 1'b1;
    end
    check("t6 fill requested", 512'(seen), 512'(1));
    repeat (3) @(posedge clk);
    #1;
    check("t6 fill still pending", 512'(mem_req.valid), 512'(1));
    rst = 1'b1;
    #1;
    check("t6 mem_req.valid on reset", 512'(mem_req.valid), 512'(0));
    check("t6 cpu_res on reset", 512'(cpu_res), 512'(0));
    check("t6 hit_count on reset", 512'(hit_count), 512'(0));
    check("t6 miss_count on reset", 512'(miss_count), 512'(0));
    cpu_req.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    last_alloc_addr = '0;
    cpu_op(32'h0000_9008, 1'b0, 32'h0, 0, rd, lat);
    check("t6 post-reset miss alloc literal", 512'(last_alloc_addr), 512'(32'h0000_9000));
    cpu_op(32'h0000_9008, 1'b0, 32'h0, 0, rd, lat);
    cpu_op(32'h0000_3000, 1'b0, 32'h0, 2, rd, lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
